// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and
// the reference function used by both the datapath and its models.
package logic_unit_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOTA = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_ANDN = 3'd7
    } op_t;

    // Computed at full width; callers truncate to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] logic_fn(
        input op_t                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOTA: r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// Generic single-entry valid/ready register slice; the upstream ready is
// combinational from the downstream ready (no skid buffer).
module logic_unit_stage #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined N-bit logic unit with accumulator chaining and
// registered result flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    localparam int S1_W = 2*WIDTH + 5;
    localparam int S2_W = WIDTH + 3;
    // Idle output reads as result 0, so the zero flag resets high.
    localparam logic [S2_W-1:0] S2_RST = {{WIDTH{1'b0}}, 3'b100};

    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_acc;
    logic             s1_clr;

    logic             s2_in_ready;
    logic [S2_W-1:0]  s2_in_data;
    logic [S2_W-1:0]  s2_data;
    logic             s2_load;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] result;

    logic_unit_stage #(
        .W       (S1_W),
        .RST_VAL ('0)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   ({in_a, in_b, in_op, in_acc, in_clr}),
        .in_ready  (in_ready),
        .out_valid (s1_valid),
        .out_data  (s1_data),
        .out_ready (s2_in_ready)
    );

    assign s1_a   = s1_data[S1_W-1 -: WIDTH];
    assign s1_b   = s1_data[WIDTH+4 -: WIDTH];
    assign s1_op  = s1_data[4:2];
    assign s1_acc = s1_data[1];
    assign s1_clr = s1_data[0];

    always_comb begin
        eff_a = s1_a;
        if (s1_acc) begin
            eff_a = s1_clr ? '0 : acc_q;
        end
        result = WIDTH'(logic_fn(op_t'(s1_op), MAX_WIDTH'(eff_a), MAX_WIDTH'(s1_b)));
    end

    assign s2_in_data = {result, ~|result, &result, ^result};
    assign s2_load    = s1_valid && s2_in_ready;

    // Updating on the S2 load edge lets the next beat in S1 see it directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (s2_load) begin
            if (s1_acc) begin
                acc_q <= result;
            end else if (s1_clr) begin
                acc_q <= '0;
            end
        end
    end

    logic_unit_stage #(
        .W       (S2_W),
        .RST_VAL (S2_RST)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   (s2_in_data),
        .in_ready  (s2_in_ready),
        .out_valid (out_valid),
        .out_data  (s2_data),
        .out_ready (out_ready)
    );

    assign out_result = s2_data[S2_W-1 -: WIDTH];
    assign out_zero   = s2_data[2];
    assign out_ones   = s2_data[1];
    assign out_parity = s2_data[0];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised checks of logic_unit_pipe at WIDTH=8.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_acc = 1'b0;
    logic       in_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_ones;
    logic       out_parity;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h30};

    localparam int N_RAND = 10000;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_clr     (in_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc, input logic clr);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        in_clr   = clr;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    // Checks any output handshake of this cycle against the expected queue, then advances one edge.
    task automatic tick();
        logic [7:0] e;
        #1;
        if (out_valid && out_ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", 64'(out_result), 64'(e));
                chk("zero",   64'(out_zero),   64'(e == 8'h00));
                chk("ones",   64'(out_ones),   64'(e == 8'hFF));
                chk("parity", 64'(out_parity), 64'(^e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle();
        repeat (4) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] m_acc;
        logic [7:0] ea;
        logic [7:0] r;
        int sent;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_zero",   64'(out_zero),   64'd1);
        chk("rst_out_ones",   64'(out_ones),   64'd0);
        chk("rst_out_parity", 64'(out_parity), 64'd0);
        chk("rst_in_ready",   64'(in_ready),   64'd1);

        // Op sweep with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0);
            exp_q.push_back(sweep_exp[i]);
            #1;
            chk("sweep_in_ready", 64'(in_ready), 64'd1);
            tick();
            idle();
            #1;
            chk("lat_early", 64'(out_valid), 64'd0);
            tick();
            #1;
            chk("lat_valid", 64'(out_valid), 64'd1);
            tick();
        end
        chk("sweep_drain", 64'(exp_q.size()), 64'd0);

        // Back-to-back accumulator chain, then read the accumulator back via OR 0.
        drive(1'b1, 8'h00, 8'h01, OP_OR,  1'b1, 1'b1); exp_q.push_back(8'h01); tick();
        drive(1'b1, 8'h00, 8'h80, OP_OR,  1'b1, 1'b0); exp_q.push_back(8'h81); tick();
        drive(1'b1, 8'h00, 8'hFF, OP_XOR, 1'b1, 1'b0); exp_q.push_back(8'h7E); tick();
        drive(1'b1, 8'h00, 8'h0F, OP_AND, 1'b1, 1'b0); exp_q.push_back(8'h0E); tick();
        drive(1'b1, 8'h00, 8'h00, OP_OR,  1'b1, 1'b0); exp_q.push_back(8'h0E); tick();
        drain("chain_drain");

        // Backpressure: out_ready low for five cycles.
        out_ready = 1'b0;
        drive(1'b1, 8'hFF, 8'h0F, OP_AND, 1'b0, 1'b0); exp_q.push_back(8'h0F);
        #1;
        chk("bp_in_ready0", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 8'h10, 8'h01, OP_OR, 1'b0, 1'b0); exp_q.push_back(8'h11);
        #1;
        chk("bp_in_ready1", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 8'hAA, 8'hFF, OP_XOR, 1'b0, 1'b0); exp_q.push_back(8'h55);
        repeat (3) begin
            #1;
            chk("stall_in_ready", 64'(in_ready),   64'd0);
            chk("hold_valid",     64'(out_valid),  64'd1);
            chk("hold_result",    64'(out_result), 64'h0F);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 8'h00, 8'h00, OP_NOR, 1'b0, 1'b0); exp_q.push_back(8'hFF);
        tick();
        drain("bp_drain");

        // Flags.
        drive(1'b1, 8'hAA, 8'h55, OP_AND,  1'b0, 1'b0); exp_q.push_back(8'h00); tick();
        drive(1'b1, 8'h00, 8'h00, OP_XNOR, 1'b0, 1'b0); exp_q.push_back(8'hFF); tick();
        drive(1'b1, 8'h01, 8'h00, OP_OR,   1'b0, 1'b0); exp_q.push_back(8'h01); tick();
        drain("flags_drain");

        // Reset with two beats in flight and accumulator 0x5A.
        drive(1'b1, 8'h00, 8'h5A, OP_OR, 1'b1, 1'b1); exp_q.push_back(8'h5A); tick();
        drain("preload_drain");
        out_ready = 1'b0;
        drive(1'b1, 8'h00, 8'hFF, OP_XOR, 1'b1, 1'b0); tick();
        drive(1'b1, 8'h11, 8'h22, OP_OR,  1'b0, 1'b0); tick();
        #1;
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        drive(1'b1, 8'h33, 8'h44, OP_OR, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("mid_rst_out_valid",  64'(out_valid),  64'd0);
        chk("mid_rst_out_zero",   64'(out_zero),   64'd1);
        chk("mid_rst_out_result", 64'(out_result), 64'd0);
        chk("mid_rst_in_ready",   64'(in_ready),   64'd1);
        out_ready = 1'b1;
        drive(1'b1, 8'h00, 8'h00, OP_OR, 1'b1, 1'b0); exp_q.push_back(8'h00); tick();
        drain("post_rst_drain");

        // Random stream against the package-function model.
        m_acc = 8'h00;
        sent = 0;
        for (int it = 0; it < 60000 && !(sent == N_RAND && exp_q.size() == 0); it++) begin
            if (sent < N_RAND) begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0);
            end else begin
                idle();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                ea = in_acc ? (in_clr ? 8'h00 : m_acc) : in_a;
                r  = 8'(logic_fn(op_t'(in_op), 64'(ea), 64'(in_b)));
                if (in_acc) begin
                    m_acc = r;
                end else if (in_clr) begin
                    m_acc = 8'h00;
                end
                exp_q.push_back(r);
                sent++;
            end
            tick();
        end
        chk("rand_sent",  64'(sent), 64'(N_RAND));
        chk("rand_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the registered, N-bit successor to the team's single-bit dataflow gate block. Applies one of eight selectable two-operand logic functions per transaction and adds an accumulator mode that chains results across transactions. Result flags are registered alongside the result. Valid/ready handshakes on both sides let it sit between streaming producers and consumers on the single datapath clock.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept the beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  function select (see Operation)
- in_acc  in  1  beat uses the accumulator as operand A and updates it
- in_clr  in  1  beat clears the accumulator to 0 before use
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  function result
- out_zero  out  1  out_result == 0
- out_ones  out  1  out_result is all ones
- out_parity  out  1  XOR-reduce of out_result

## Operation
- Op encoding: 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 ANDN (A & ~B).
- All functions are purely bitwise, WIDTH bits wide. There is no carry and no width growth.
- Two register stages:
  - S1 captures in_a, in_b, in_op, in_acc and in_clr on an input handshake (in_valid && in_ready).
  - S2 computes the function on S1 contents during S1→S2 transfer and registers the result and flags.
- Effective operand A at compute:
  - in_acc=0: in_a.
  - in_acc=1: 0 if in_clr=1, else the current accumulator.
- Accumulator (WIDTH bits) loads the result on the same edge as an S2 load of an in_acc=1 beat.
- in_clr=1 with in_acc=0 clears the accumulator to 0 on S2 load. That beat's result uses in_a normally.
- Back-to-back accumulator beats chain correctly. Beat n+1 sees the value written by beat n, with no bubble.
- Beats with in_acc=0 leave the accumulator untouched, except when in_clr=1.
- Flow control:
  - S2 advances when it is empty or out_ready=1.
  - S1 advances into S2 when S2 advances.
  - in_ready = S1 empty OR S1 advancing this cycle (combinational from out_ready; no skid buffer).
- Order is strictly preserved. No beat is dropped or duplicated.
- out_result and flags hold stable while out_valid=1 and out_ready=0.
- Reset values: S1/S2 valid=0, out_valid=0, out_result=0, out_zero=1, out_ones=0, out_parity=0, accumulator=0. in_ready=1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats, including one held under backpressure. The accumulator clears.
- in_valid is ignored while rst=1.
- Undefined in_op values cannot occur (3-bit field fully decoded).

## Timing
- Latency: input handshake on edge k → out_valid=1 after edge k+1, i.e. two edges. Result is visible in cycle k+2.
- Throughput: one beat per cycle when out_ready is held high.
- Stall with both stages full and out_ready=0: in_ready=0.
- out_ready rising releases one beat per cycle. in_ready rises in the same cycle as out_ready (combinational path).
- Simultaneous output handshake and input handshake on a full pipe is legal. Occupancy stays at 2.
- Flags are registered together with the result, with no extra cycle.

## Structure
- Shared package logic_unit_pkg:
  - op encoding constants (OP_AND … OP_ANDN) as a 3-bit typedef.
  - a pure function computing the result from (op, a, b), for reuse by the bench model.
- One natural sub-module: logic_unit_stage, a generic valid/ready register slice parametrised on payload width.
  - Instantiated twice.
  - The compute and accumulator logic stays in the top.

## Test plan
- WIDTH=8. Sweep ops 0..7 with A=0xF0, B=0xCC, out_ready=1. Required results: 0xC0, 0xFC, 0x0F, 0x3F, 0x03, 0x3C, 0xC3, 0x30. Each arrives 2 cycles after its handshake.
- Accumulator chain, back-to-back:
  - OR clr B=0x01 → 0x01.
  - OR B=0x80 → 0x81.
  - XOR B=0xFF → 0x7E.
  - AND B=0x0F → 0x0E.
  - Accumulator ends at 0x0E.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepted beats.
  - out_result holds the first result.
  - On release, all 4 results appear in order with no loss.
- Flags:
  - AND 0xAA,0x55 → result 0x00, zero=1, parity=0.
  - XNOR 0x00,0x00 → 0xFF, ones=1, parity=0.
  - OR 0x01,0x00 → parity=1.
- Reset mid-stream: assert rst with 2 beats in flight and accumulator=0x5A.
  - Next cycle: out_valid=0, out_zero=1.
  - A following acc OR B=0x00 beat yields 0x00.
- Random: 10k beats with random ops, acc/clr bits and out_ready, checked against a package-function reference model.
